instr_fetch: RTL

Sequential instruction-fetch unit for the single-cycle/multicycle CPU labs. It owns the PC, issues word reads to instruction memory over a req/ack handshake, and presents each fetched instruction to the downstream opcode decoder and register stage through a valid/ready handshake. It accepts branch redirects and a halt request from the execute side.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/instr_fetch.sv | 86 ++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-lab types: fetch FSM states and PC geometry.
package cpu_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] INSTR_BYTES = 32'd4;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALTED} fetch_state_t;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
    return a & ~32'h3;
  endfunction
endpackage

// File: rtl/instr_fetch.sv
// Sequential instruction fetch: owns the PC, reads imem over req/ack and hands
// each instruction downstream over valid/ready, with branch redirect and halt.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_data_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_plus4_o,
  input  logic            branch_i,
  input  logic [PC_W-1:0] branch_target_i,
  input  logic            halt_i
);
  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  // Redirect taken while a request is outstanding is parked here so the bus
  // address stays stable until the stale transfer is acked and dropped.
  logic [PC_W-1:0] redir_pc;
  logic            flush;
  logic            halt_pend;
  logic [PC_W-1:0] tgt;

  assign tgt         = align_pc(branch_target_i);
  assign imem_req_o  = (state == REQ);
  assign imem_addr_o = pc;
  assign pc_plus4_o  = pc_o + INSTR_BYTES;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      redir_pc      <= '0;
      flush         <= 1'b0;
      halt_pend     <= 1'b0;
      instr_valid_o <= 1'b0;
      instr_o       <= '0;
      pc_o          <= '0;
    end else begin
      case (state)
        IDLE: state <= (halt_i || halt_pend) ? HALTED : REQ;
        REQ: begin
          if (halt_i) halt_pend <= 1'b1;
          if (imem_ack_i) begin
            if (flush || branch_i) begin
              flush <= 1'b0;
              pc    <= branch_i ? tgt : redir_pc;
              state <= (halt_pend || halt_i) ? HALTED : IDLE;
            end else begin
              instr_o       <= imem_data_i;
              pc_o          <= pc;
              instr_valid_o <= 1'b1;
              state         <= HOLD;
            end
          end else if (branch_i) begin
            redir_pc <= tgt;
            flush    <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_ready_i) begin
            instr_valid_o <= 1'b0;
            pc            <= branch_i ? tgt : pc + INSTR_BYTES;
            state         <= (halt_i || halt_pend) ? HALTED : REQ;
          end else if (branch_i) begin
            instr_valid_o <= 1'b0;
            pc            <= tgt;
            state         <= REQ;
          end else if (halt_i) begin
            halt_pend <= 1'b1;
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
